// File: rtl/aqed_resp_checker.sv
// A-QED response checker: pairs in-order read returns with issued-read tags and compares original vs duplicate data.
// Optional watchdog on pending reads is enabled with the AQED_TIMEOUT_EN macro.
module aqed_resp_checker #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int TAG_DEPTH  = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_en,
  input  logic                         flush,
  input  logic                         ren_in,
  input  logic [ADDR_WIDTH-1:0]        addr_in,
  input  logic                         is_orig,
  input  logic                         is_dup,
  input  logic                         valid_out,
  input  logic [DATA_WIDTH-1:0]        data_out,
  output logic                         qed_done,
  output logic                         qed_check,
  output logic [DATA_WIDTH-1:0]        orig_data,
  output logic [DATA_WIDTH-1:0]        dup_data,
  output logic [ADDR_WIDTH-1:0]        orig_addr,
  output logic [$clog2(TAG_DEPTH):0]   pending,
  output logic                         err_overflow,
  output logic                         err_spurious,
  output logic                         err_timeout
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] TAG_OTHER = 2'd0;
  localparam logic [1:0] TAG_ORIG  = 2'd1;
  localparam logic [1:0] TAG_DUP   = 2'd2;

  if (TAG_DEPTH < 2 || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("TAG_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ORIG,
    S_WAIT_DUP,
    S_DONE
  } state_t;

  state_t           state;
  logic             dup_issued;
  logic [1:0]       tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic       empty;
  logic       full;
  logic       do_pop;
  logic       do_push;
  logic [1:0] push_tag;
  logic [1:0] head_tag;

  assign empty    = (pending == '0);
  assign full     = (pending == CNT_W'(TAG_DEPTH));
  assign do_pop   = valid_out && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push  = ren_in && (!full || do_pop);
  assign head_tag = tag_mem[rd_ptr];

  always_comb begin
    push_tag = TAG_OTHER;
    if (is_orig && state == S_IDLE)
      push_tag = TAG_ORIG;
    else if (is_dup && !is_orig && !dup_issued &&
             (state == S_WAIT_ORIG || state == S_WAIT_DUP))
      push_tag = TAG_DUP;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      dup_issued   <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      pending      <= '0;
      qed_done     <= 1'b0;
      qed_check    <= 1'b0;
      orig_data    <= '0;
      dup_data     <= '0;
      orig_addr    <= '0;
      err_overflow <= 1'b0;
      err_spurious <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem[i] <= TAG_OTHER;
    end else if (clk_en) begin
      if (flush) begin
        state      <= S_IDLE;
        dup_issued <= 1'b0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        pending    <= '0;
        qed_done   <= 1'b0;
        qed_check  <= 1'b0;
        orig_data  <= '0;
        dup_data   <= '0;
        orig_addr  <= '0;
      end else begin
        if (ren_in && full && !do_pop) err_overflow <= 1'b1;
        if (valid_out && empty)        err_spurious <= 1'b1;

        if (do_push) begin
          tag_mem[wr_ptr] <= push_tag;
          wr_ptr          <= wr_ptr + PTR_W'(1);
          if (push_tag == TAG_ORIG) begin
            state     <= S_WAIT_ORIG;
            orig_addr <= addr_in;
          end
          if (push_tag == TAG_DUP) dup_issued <= 1'b1;
        end

        if (do_pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
          if (head_tag == TAG_ORIG && state == S_WAIT_ORIG) begin
            orig_data <= data_out;
            state     <= S_WAIT_DUP;
          end else if (head_tag == TAG_DUP) begin
            if (state == S_WAIT_DUP) begin
              dup_data  <= data_out;
              qed_done  <= 1'b1;
              qed_check <= (orig_data == data_out);
              state     <= S_DONE;
            end else if (state == S_WAIT_ORIG) begin
              // Duplicate overtaking the original breaks in-order return.
              err_spurious <= 1'b1;
            end
          end
        end

        case ({do_push, do_pop})
          2'b10:   pending <= pending + CNT_W'(1);
          2'b01:   pending <= pending - CNT_W'(1);
          default: pending <= pending;
        endcase
      end
    end
  end

`ifdef AQED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] wd_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else if (clk_en) begin
      if (flush || do_pop || empty) begin
        wd_cnt <= '0;
      end else if (wd_cnt != TO_W'(TIMEOUT)) begin
        wd_cnt <= wd_cnt + TO_W'(1);
        if (wd_cnt == TO_W'(TIMEOUT - 1)) err_timeout <= 1'b1;
      end
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

endmodule
